sdram_host_arbiter: RTL and testbench
=====================================

// Module: sdram_host_arbiter
// PURPOSE
//  Shares the single SDRAM controller host port (haddr/data_input/data_output/busy/rd_enable/wr_enable)
//  between two requesters (m0, m1) with round-robin arbitration. Sequences each access as
//  issue -> busy rise -> busy fall, returns read data with a done pulse, and flags a hung controller.
//  Sits between board/test front-ends (button/dip interface, pattern tester) and the sdram controller.
// PARAMETERS
//  HADDR_WIDTH    24  host address width, matches controller haddr
//  DATA_WIDTH     16  host data width
//  TIMEOUT_WIDTH  16  watchdog counter width; timeout after 2**TIMEOUT_WIDTH-1 cycles
// PORTS
//  clk         in   1            single clock, all logic on posedge
//  rst_n       in   1            reset, asynchronous assert, active-low
//  m0_req      in   1            m0 access request, level; hold until m0_gnt
//  m0_we       in   1            1=write, 0=read; valid while m0_req
//  m0_addr     in   HADDR_WIDTH  m0 address
//  m0_wdata    in   DATA_WIDTH   m0 write data
//  m0_gnt      out  1            1-cycle pulse: m0 request accepted, inputs latched
//  m0_done     out  1            1-cycle pulse: m0 access complete, rdata valid if read
//  m1_*        --   --           identical set for requester 1 (m1_req..m1_done)
//  rdata       out  DATA_WIDTH   read data of last completed read; shared by both requesters
//  err         out  1            sticky watchdog timeout flag
//  haddr       out  HADDR_WIDTH  to controller
//  data_input  out  DATA_WIDTH   to controller (write data)
//  data_output in   DATA_WIDTH   from controller (read data)
//  busy        in   1            from controller
//  rd_enable   out  1            to controller, 1-cycle pulse
//  wr_enable   out  1            to controller, 1-cycle pulse
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all outputs 0; rr pointer favours m0; watchdog 0; err 0.
//  - All outputs are registered. FSM: IDLE -> ISSUE -> WAIT_BUSY -> BUSY -> DONE -> IDLE.
//  - IDLE: if (m0_req|m1_req) & ~busy, grant: only one requesting -> it; both -> the one not
//    granted last (rr pointer toggles on every grant). Latch we/addr/wdata, go ISSUE.
//    busy=1 in IDLE blocks all grants.
//  - ISSUE (1 cycle): mX_gnt=1; wr_enable=we or rd_enable=~we, =1; haddr/data_input drive latched values.
//    Grant latency: req sampled at edge N -> gnt/enable high cycle N+1.
//  - WAIT_BUSY: stay until busy=1, then BUSY. BUSY: stay until busy=0; on that edge capture
//    data_output into rdata if read (rdata unchanged on writes), go DONE.
//  - DONE (1 cycle): mX_done=1 for the granted requester, then IDLE. No new grant in DONE.
//  - haddr/data_input hold latched values until the next grant; rd/wr_enable never both high.
//  - Requester keeping req high after gnt gets a new transaction; both held high -> strict
//    alternation m0,m1,m0,... with exactly one idle cycle (IDLE) between DONE and next ISSUE.
//  - Watchdog: counts each cycle in WAIT_BUSY/BUSY, cleared in ISSUE. On reaching all-ones:
//    err<=1 (sticky until reset), go DONE, done pulses, rdata unchanged.
//  - Counter width: saturates, no wrap. Reset mid-access: immediate IDLE, no done pulse, outputs 0.
//  - req changes while not in IDLE are ignored until IDLE samples them.
// TESTING
//  - m0 write addr=0x000123 wdata=0xA5A5, busy high 3 cycles after issue -> m0_gnt & wr_enable
//    same cycle, haddr=0x000123, data_input=0xA5A5, m0_done 1 cycle after busy falls, rdata unchanged.
//  - m1 read addr=0x00FFFF, controller returns 0x5A3C when busy falls -> rd_enable 1 cycle,
//    m1_done pulse, rdata=0x5A3C, m0_done stays 0.
//  - m0_req & m1_req held high 4 transactions -> grants m0,m1,m0,m1; never two enables in one access.
//  - TIMEOUT_WIDTH=4, busy never rises after issue -> after 15 cycles err=1, done pulse, FSM back
//    to IDLE; err stays 1 across further good accesses.
//  - busy held high in IDLE with m0_req=1 -> no gnt, no enable until busy=0, then grant next edge.
//  - rst_n low during BUSY -> all outputs 0 asynchronously, no done; after release m0 write completes normally.

Source files
------------

// File: rtl/sdram_host_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller host port between two requesters.
// Each access runs issue -> busy rise -> busy fall; a watchdog flags a hung controller.
`timescale 1ns/1ps

module sdram_host_arbiter #(
    parameter int HADDR_WIDTH   = 24,
    parameter int DATA_WIDTH    = 16,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   m0_req,
    input  logic                   m0_we,
    input  logic [HADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0]  m0_wdata,
    output logic                   m0_gnt,
    output logic                   m0_done,
    input  logic                   m1_req,
    input  logic                   m1_we,
    input  logic [HADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0]  m1_wdata,
    output logic                   m1_gnt,
    output logic                   m1_done,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic                   err,
    output logic [HADDR_WIDTH-1:0] haddr,
    output logic [DATA_WIDTH-1:0]  data_input,
    input  logic [DATA_WIDTH-1:0]  data_output,
    input  logic                   busy,
    output logic                   rd_enable,
    output logic                   wr_enable
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] WDOG_MAX  = '1;
    localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

    state_t state, state_nxt;

    logic                     prio_m1, prio_m1_nxt;
    logic                     cur_m1, cur_m1_nxt;
    logic                     cur_we, cur_we_nxt;
    logic [TIMEOUT_WIDTH-1:0] wdog, wdog_nxt;

    logic                     m0_gnt_nxt, m1_gnt_nxt, m0_done_nxt, m1_done_nxt;
    logic                     rd_enable_nxt, wr_enable_nxt, err_nxt;
    logic [DATA_WIDTH-1:0]    rdata_nxt, data_input_nxt;
    logic [HADDR_WIDTH-1:0]   haddr_nxt;

    logic grant, pick_m1, pick_we;
    logic normal_done, timeout;

    // Both requesting: the one not granted last wins; a lone requester always wins.
    assign pick_m1     = m1_req & (~m0_req | prio_m1);
    assign pick_we     = pick_m1 ? m1_we : m0_we;
    assign grant       = (state == S_IDLE) & (m0_req | m1_req) & ~busy;
    assign normal_done = (state == S_BUSY) & ~busy;
    // Watchdog fires on the cycle the counter would reach all-ones, unless completing normally.
    assign timeout     = (wdog == WDOG_LAST) &
                         ((state == S_WAIT_BUSY) | ((state == S_BUSY) & busy));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (timeout) begin
                    state_nxt = S_DONE;
                end else if (busy) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (normal_done || timeout) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and the access context.
    always_comb begin
        m0_gnt_nxt     = 1'b0;
        m1_gnt_nxt     = 1'b0;
        m0_done_nxt    = 1'b0;
        m1_done_nxt    = 1'b0;
        rd_enable_nxt  = 1'b0;
        wr_enable_nxt  = 1'b0;
        err_nxt        = err;
        rdata_nxt      = rdata;
        haddr_nxt      = haddr;
        data_input_nxt = data_input;
        prio_m1_nxt    = prio_m1;
        cur_m1_nxt     = cur_m1;
        cur_we_nxt     = cur_we;
        wdog_nxt       = wdog;

        case (state)
            S_IDLE: begin
                if (grant) begin
                    cur_m1_nxt     = pick_m1;
                    cur_we_nxt     = pick_we;
                    prio_m1_nxt    = ~pick_m1;
                    haddr_nxt      = pick_m1 ? m1_addr : m0_addr;
                    data_input_nxt = pick_m1 ? m1_wdata : m0_wdata;
                    m0_gnt_nxt     = ~pick_m1;
                    m1_gnt_nxt     = pick_m1;
                    wr_enable_nxt  = pick_we;
                    rd_enable_nxt  = ~pick_we;
                end
            end
            S_ISSUE: begin
                wdog_nxt = '0;
            end
            S_WAIT_BUSY, S_BUSY: begin
                wdog_nxt = (wdog == WDOG_MAX) ? wdog : wdog + 1'b1;
                if (normal_done || timeout) begin
                    m0_done_nxt = ~cur_m1;
                    m1_done_nxt = cur_m1;
                end
                if (normal_done) begin
                    if (!cur_we) begin
                        rdata_nxt = data_output;
                    end
                end else if (timeout) begin
                    err_nxt = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
            rd_enable  <= 1'b0;
            wr_enable  <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            haddr      <= '0;
            data_input <= '0;
            prio_m1    <= 1'b0;
            cur_m1     <= 1'b0;
            cur_we     <= 1'b0;
            wdog       <= '0;
        end else begin
            m0_gnt     <= m0_gnt_nxt;
            m1_gnt     <= m1_gnt_nxt;
            m0_done    <= m0_done_nxt;
            m1_done    <= m1_done_nxt;
            rd_enable  <= rd_enable_nxt;
            wr_enable  <= wr_enable_nxt;
            err        <= err_nxt;
            rdata      <= rdata_nxt;
            haddr      <= haddr_nxt;
            data_input <= data_input_nxt;
            prio_m1    <= prio_m1_nxt;
            cur_m1     <= cur_m1_nxt;
            cur_we     <= cur_we_nxt;
            wdog       <= wdog_nxt;
        end
    end

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Scoreboard bench for sdram_host_arbiter: stimulus pushes expected grants/completions,
// a negedge monitor pops and compares them; a behavioural controller drives busy.
`timescale 1ns/1ps

module tb_sdram_host_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;

    typedef struct packed {
        logic          m1;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } gnt_t;

    typedef struct packed {
        logic          m1;
        logic [DW-1:0] rd;
        logic          err;
    } done_t;

    logic          clk, rst_n;
    logic          m0_req, m0_we, m0_gnt, m0_done;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m1_req, m1_we, m1_gnt, m1_done;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [DW-1:0] rdata, data_input, data_output;
    logic [AW-1:0] haddr;
    logic          err, busy, rd_enable, wr_enable;
    logic          model_busy, hold_busy, hang;
    int            busy_len;
    logic [DW-1:0] rd_val, exp_rdata;
    logic          exp_err;

    gnt_t  gq[$];
    done_t dq[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;

    assign busy = model_busy | hold_busy;

    sdram_host_arbiter #(
        .HADDR_WIDTH  (AW),
        .DATA_WIDTH   (DW),
        .TIMEOUT_WIDTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_req     (m0_req),
        .m0_we      (m0_we),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_gnt     (m0_gnt),
        .m0_done    (m0_done),
        .m1_req     (m1_req),
        .m1_we      (m1_we),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_gnt     (m1_gnt),
        .m1_done    (m1_done),
        .rdata      (rdata),
        .err        (err),
        .haddr      (haddr),
        .data_input (data_input),
        .data_output(data_output),
        .busy       (busy),
        .rd_enable  (rd_enable),
        .wr_enable  (wr_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Controller model: busy rises the cycle after an enable, stays busy_len cycles.
    initial begin
        logic was_read;
        model_busy  = 1'b0;
        data_output = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (rd_enable || wr_enable) && !hang) begin
                was_read = rd_enable;
                @(posedge clk);
                #1 model_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1;
                data_output = was_read ? rd_val : 16'hDEAD;
                model_busy  = 1'b0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        gnt_t  g;
        done_t d;
        if (rst_n) begin
            if (rd_enable || wr_enable) begin
                chk("one_enable", {30'd0, rd_enable, wr_enable}, rd_enable ? 32'd2 : 32'd1);
                if (!(m0_gnt || m1_gnt)) chk("enable_without_gnt", {rd_enable, wr_enable}, 0);
            end
            if (m0_gnt || m1_gnt) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", {m1_gnt, m0_gnt}, 0);
                end else begin
                    g = gq.pop_front();
                    chk("gnt_owner", {m1_gnt, m0_gnt}, g.m1 ? 2 : 1);
                    chk("wr_enable", wr_enable, g.we);
                    chk("rd_enable", rd_enable, !g.we);
                    chk("haddr", haddr, g.addr);
                    chk("data_input", data_input, g.wd);
                end
            end
            if (m0_done || m1_done) begin
                if (dq.size() == 0) begin
                    chk("done_unexpected", {m1_done, m0_done}, 0);
                end else begin
                    d = dq.pop_front();
                    chk("done_owner", {m1_done, m0_done}, d.m1 ? 2 : 1);
                    chk("rdata", rdata, d.rd);
                    chk("err", err, d.err);
                end
            end
        end
    end

    task automatic expect_access(input logic m, input logic we, input logic [AW-1:0] a,
                                 input logic [DW-1:0] wd);
        gq.push_back('{m1: m, we: we, addr: a, wd: wd});
        if (!we) exp_rdata = rd_val;
        dq.push_back('{m1: m, rd: exp_rdata, err: exp_err});
    endtask

    task automatic set_req(input logic m, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic r);
        if (!m) begin
            m0_we = we; m0_addr = a; m0_wdata = wd; m0_req = r;
        end else begin
            m1_we = we; m1_addr = a; m1_wdata = wd; m1_req = r;
        end
    endtask

    task automatic do_req(input logic m, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd);
        logic got;
        expect_access(m, we, a, wd);
        set_req(m, we, a, wd, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #1;
            got = m ? m1_gnt : m0_gnt;
        end
        set_req(m, we, a, wd, 1'b0);
        chk("gnt_wait", got, 1);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #1;
            got = m ? m1_done : m0_done;
        end
        chk("done_wait", got, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nd, last_done, n;
        logic got;
        rst_n = 1'b0; hold_busy = 1'b0; hang = 1'b0; busy_len = 3;
        rd_val = '0; exp_rdata = '0; exp_err = 1'b0;
        set_req(0, 0, '0, '0, 0);
        set_req(1, 0, '0, '0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {m0_gnt, m1_gnt, m0_done, m1_done, rd_enable, wr_enable, err}, 0);
        chk("reset_haddr", haddr, 0);
        chk("reset_data_input", data_input, 0);
        chk("reset_rdata", rdata, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // m0 write, then m1 read
        do_req(0, 1, 24'h000123, 16'hA5A5);
        rd_val = 16'h5A3C;
        do_req(1, 0, 24'h00FFFF, 16'h0000);

        // Both held: m0,m1,m0,m1 with one IDLE between DONE and next ISSUE
        rd_val = 16'h2222;
        expect_access(0, 1, 24'h000010, 16'h1111);
        expect_access(1, 0, 24'h000020, 16'h0000);
        expect_access(0, 1, 24'h000010, 16'h1111);
        expect_access(1, 0, 24'h000020, 16'h0000);
        set_req(0, 1, 24'h000010, 16'h1111, 1);
        set_req(1, 0, 24'h000020, 16'h0000, 1);
        nd = 0; last_done = 0;
        for (int i = 0; i < 200 && nd < 4; i++) begin
            @(posedge clk); #1;
            if ((m0_gnt || m1_gnt) && nd > 0) chk("rr_gap", cyc - last_done, 2);
            if (m0_done || m1_done) begin
                nd++;
                last_done = cyc;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("rr_done_count", nd, 4);
        repeat (3) @(posedge clk); #1;

        // busy high in IDLE blocks grants
        hold_busy = 1'b1;
        set_req(0, 1, 24'h000456, 16'h1357, 1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("busy_block", {m0_gnt, m1_gnt, rd_enable, wr_enable}, 0);
        end
        expect_access(0, 1, 24'h000456, 16'h1357);
        hold_busy = 1'b0;
        @(posedge clk); #1;
        chk("busy_release_gnt", m0_gnt, 1);
        m0_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #1;
            got = m0_done;
        end
        chk("busy_release_done", got, 1);

        // Hung controller: watchdog fires after 15 cycles waiting
        hang = 1'b1;
        exp_err = 1'b1;
        gq.push_back('{m1: 1'b0, we: 1'b0, addr: 24'h000ABC, wd: 16'h0000});
        dq.push_back('{m1: 1'b0, rd: exp_rdata, err: 1'b1});
        set_req(0, 0, 24'h000ABC, 16'h0000, 1);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #1;
            got = m0_gnt;
        end
        m0_req = 1'b0;
        chk("to_gnt_wait", got, 1);
        n = 0; got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk); #1;
            n++;
            got = m0_done;
        end
        chk("to_latency", n, 16);
        chk("to_err", err, 1);
        hang = 1'b0;
        repeat (2) @(posedge clk); #1;

        // err stays set across a good access
        rd_val = 16'h0F0F;
        do_req(1, 0, 24'h000777, 16'h0000);
        chk("err_sticky", err, 1);

        // Reset asserted mid-BUSY
        busy_len = 6;
        rd_val = 16'hBEEF;
        gq.push_back('{m1: 1'b0, we: 1'b0, addr: 24'h000999, wd: 16'h0000});
        set_req(0, 0, 24'h000999, 16'h0000, 1);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #1;
            got = m0_gnt;
        end
        m0_req = 1'b0;
        chk("rst_gnt_wait", got, 1);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_in_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", {m0_gnt, m1_gnt, m0_done, m1_done, rd_enable, wr_enable, err}, 0);
        chk("async_rst_haddr", haddr, 0);
        chk("async_rst_data_input", data_input, 0);
        chk("async_rst_rdata", rdata, 0);
        exp_rdata = '0; exp_err = 1'b0;
        got = 1'b1;
        for (int i = 0; i < 20 && got; i++) begin
            @(posedge clk); #1;
            got = busy;
            chk("no_done_in_reset", {m0_done, m1_done}, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        busy_len = 3;
        do_req(0, 1, 24'h000ABC, 16'h2468);
        chk("err_after_reset", err, 0);

        repeat (3) @(posedge clk); #1;
        chk("gnt_queue_empty", gq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
